// File: rtl/seq_divider_pkg.sv
// Shared types and sizing helpers for the restoring sequential divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  localparam int DIV_WIDTH = 32;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/seq_divider_ripple_subtractor.sv
// Ripple-carry subtractor a - b built from a full-adder chain (inverted b, carry-in 1).
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module ripple_subtractor #(
  parameter int N = 33
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         borrow_o
);
  logic [N:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_fa
    full_adder u_fa (
      .a_i (a_i[i]),
      .b_i (~b_i[i]),
      .c_i (carry[i]),
      .s_o (diff_o[i]),
      .c_o (carry[i+1])
    );
  end

  // No carry out of the top bit means a < b.
  assign borrow_o = ~carry[N];
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per cycle, signed or unsigned,
// with valid/ready handshakes on both operand and result sides.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = cnt_width(WIDTH);

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  div_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] prem_q;
  logic [WIDTH-1:0] dvs_q;
  logic             signed_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             div_zero_q;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic             keep;

  always_comb begin
    dvd_mag = (in_signed && dividend[WIDTH-1]) ? neg(dividend) : dividend;
    dvs_mag = (in_signed && divisor[WIDTH-1])  ? neg(divisor)  : divisor;
  end

  assign shifted = {prem_q, q_q[WIDTH-1]};

  ripple_subtractor #(
    .N (WIDTH + 1)
  ) u_sub (
    .a_i      (shifted),
    .b_i      ({1'b0, dvs_q}),
    .diff_o   (trial),
    .borrow_o (borrow)
  );

  // Negative trial (sign bit or borrow) restores the shifted partial remainder.
  assign keep = trial[WIDTH] | borrow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      q_q         <= '0;
      prem_q      <= '0;
      dvs_q       <= '0;
      signed_q    <= 1'b0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            signed_q   <= in_signed;
            q_q        <= dvd_mag;
            dvs_q      <= dvs_mag;
            qneg_q     <= in_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            rneg_q     <= in_signed & dividend[WIDTH-1];
            prem_q     <= '0;
            cnt_q      <= CW'(WIDTH - 1);
            if (divisor == '0) begin
              quotient_q  <= '1;
              remainder_q <= dividend;
              div_zero_q  <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= DIV;
            end
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        DIV: begin
          q_q    <= {q_q[WIDTH-2:0], ~keep};
          prem_q <= keep ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          if (cnt_q == '0) begin
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        FIX: begin
          quotient_q  <= (signed_q && qneg_q) ? neg(q_q)    : q_q;
          remainder_q <= (signed_q && rneg_q) ? neg(prem_q) : prem_q;
          div_zero_q  <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH = 32).
module tb_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  int errors = 0;
  int checks = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic sg, input logic [31:0] a, input logic [31:0] b);
    in_signed = sg;
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
  endtask

  // Waits (bounded) for in_ready, lets the next rising edge take the operands,
  // then scrambles the inputs so any late sampling would be visible.
  task automatic accept();
    int n = 0;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    in_signed = ~in_signed;
  endtask

  // Latency counted in cycles after the accept edge: the first negedge is cycle 1.
  task automatic wait_out(output int lat, output logic ir1);
    lat = 0;
    ir1 = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) ir1 = in_ready;
    end while (!out_valid && lat < 100);
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic sg, input logic [31:0] a, input logic [31:0] b,
                     input int exp_lat, input logic [31:0] eq, input logic [31:0] er, input logic ez);
    int   lat;
    logic ir1;
    drive(sg, a, b);
    accept();
    wait_out(lat, ir1);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dz"}, {31'b0, div_zero}, {31'b0, ez});
    consume();
  endtask

  initial begin
    int   lat;
    logic ir1;
    logic ov_seen;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b0;

    #12;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_div_zero", {31'b0, div_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // 100 / 7 unsigned, with in_ready low in the cycle after accept
    drive(1'b0, 32'd100, 32'd7);
    accept();
    wait_out(lat, ir1);
    chk("u100_7_in_ready_low", {31'b0, ir1}, 32'd0);
    chk("u100_7_lat", 32'(lat), 32'd34);
    chk("u100_7_q", quotient, 32'd14);
    chk("u100_7_r", remainder, 32'd2);
    chk("u100_7_dz", {31'b0, div_zero}, 32'd0);
    consume();

    run("s_m7_2",  1'b1, 32'hFFFF_FFF9, 32'd2,         34, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run("s_7_m2",  1'b1, 32'd7,         32'hFFFF_FFFE, 34, 32'hFFFF_FFFD, 32'd1,         1'b0);
    run("u_dz",    1'b0, 32'h1234,      32'd0,         1,  32'hFFFF_FFFF, 32'h1234,      1'b1);
    run("s_dz",    1'b1, 32'h1234,      32'd0,         1,  32'hFFFF_FFFF, 32'h1234,      1'b1);
    run("s_neg_dz",1'b1, 32'hFFFF_FFFB, 32'd0,         1,  32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
    run("s_min_m1",1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h8000_0000, 32'd0,         1'b0);
    run("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1,         34, 32'hFFFF_FFFF, 32'd0,         1'b0);
    run("u_min_max",1'b0,32'h8000_0000, 32'hFFFF_FFFF, 34, 32'd0,         32'h8000_0000, 1'b0);
    run("s_m100_m7",1'b1,32'hFFFF_FF9C, 32'hFFFF_FFF9, 34, 32'd14,        32'hFFFF_FFFE, 1'b0);

    // Backpressure: hold result for 5 cycles with a pending operand presented
    drive(1'b0, 32'd20, 32'd3);
    accept();
    wait_out(lat, ir1);
    chk("bp_lat", 32'(lat), 32'd34);
    drive(1'b0, 32'd9, 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_q", quotient, 32'd6);
      chk("bp_r", remainder, 32'd2);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_released_out_valid", {31'b0, out_valid}, 32'd0);
    chk("bp_released_in_ready", {31'b0, in_ready}, 32'd1);
    accept();
    wait_out(lat, ir1);
    chk("bp_pending_lat", 32'(lat), 32'd34);
    chk("bp_pending_q", quotient, 32'd2);
    chk("bp_pending_r", remainder, 32'd1);
    consume();

    // Asynchronous reset in the middle of an iteration
    drive(1'b0, 32'h0000_FFFF, 32'd3);
    accept();
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_q", quotient, 32'd0);
    chk("midrst_r", remainder, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    ov_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) ov_seen = 1'b1;
    end
    chk("midrst_no_result", {31'b0, ov_seen}, 32'd0);
    run("u50_5", 1'b0, 32'd50, 32'd5, 34, 32'd10, 32'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
